// File: rtl/axi_pkg.sv
// Shared AXI encodings used by the SRAM-backed slave ports.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

endpackage

// File: rtl/axi_sram_write_slave_if.sv
// AXI4 write address, write data and write response channels of one slave port.
interface axi_sram_write_slave_if #(
  parameter int ID_WIDTH = 8
);

  logic [ID_WIDTH-1:0] AWID_S;
  logic [31:0]         AWADDR_S;
  logic [3:0]          AWLEN_S;
  logic [2:0]          AWSIZE_S;
  logic [1:0]          AWBURST_S;
  logic                AWVALID_S;
  logic                AWREADY_S;
  logic [31:0]         WDATA_S;
  logic [3:0]          WSTRB_S;
  logic                WLAST_S;
  logic                WVALID_S;
  logic                WREADY_S;
  logic [ID_WIDTH-1:0] BID_S;
  logic [1:0]          BRESP_S;
  logic                BVALID_S;
  logic                BREADY_S;

  modport master (
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  AWREADY_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    input  WREADY_S,
    input  BID_S, BRESP_S, BVALID_S,
    output BREADY_S
  );

  modport slave (
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output AWREADY_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S,
    output WREADY_S,
    output BID_S, BRESP_S, BVALID_S,
    input  BREADY_S
  );

endinterface

// File: rtl/axi_sram_write_slave.sv
// AXI4 write responder driving a byte-strobed SRAM, one outstanding burst at a time.
// Define AXI_WR_SLV_ERRCHK_EN to enable size/burst/length checking with SLVERR responses.
module axi_sram_write_slave
  import axi_pkg::*;
#(
  parameter int ID_WIDTH       = 8,
  parameter int MEM_ADDR_WIDTH = 14
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  axi_sram_write_slave_if.slave     bus,
  output logic                      MEM_CS,
  output logic [3:0]                MEM_WE,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_A,
  output logic [31:0]               MEM_DI
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                    r_state;
  logic [ID_WIDTH-1:0]       r_id;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [1:0]                r_burst;
  logic [MEM_ADDR_WIDTH-1:0] r_last_a;
  logic [31:0]               r_last_di;

  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_wr_ok;
  logic [MEM_ADDR_WIDTH-1:0] w_addr_nxt;

  assign w_aw_hs = bus.AWVALID_S && (r_state == S_IDLE) && !ARESET;
  assign w_w_hs  = bus.WVALID_S && (r_state == S_DATA);
  // Natural overflow of the word address wraps INCR bursts at the top of the SRAM.
  assign w_addr_nxt = (r_burst == BURST_FIXED) ? r_addr : r_addr + 1'b1;

`ifdef AXI_WR_SLV_ERRCHK_EN
  logic [3:0] r_len;
  logic [3:0] r_cnt;
  logic       r_err;
  logic       r_aw_err;
  logic       r_over;
  logic       w_aw_bad;
  logic       w_beat_err;

  assign w_aw_bad   = (bus.AWSIZE_S != SIZE_4B) ||
                      !((bus.AWBURST_S == BURST_FIXED) || (bus.AWBURST_S == BURST_INCR));
  // r_over marks that the beat count has passed AWLEN; every such beat is an error.
  assign w_beat_err = w_w_hs && ((bus.WLAST_S && (r_cnt != r_len)) || r_over);
  assign w_wr_ok    = w_w_hs && !r_aw_err && !r_over;
  assign bus.BRESP_S = ((r_state == S_RESP) && r_err) ? RESP_SLVERR : RESP_OKAY;
`else
  assign w_wr_ok     = w_w_hs;
  assign bus.BRESP_S = RESP_OKAY;
`endif

  assign bus.AWREADY_S = (r_state == S_IDLE) && !ARESET;
  assign bus.WREADY_S  = (r_state == S_DATA);
  assign bus.BVALID_S  = (r_state == S_RESP);
  assign bus.BID_S     = r_id;

  assign MEM_CS = w_wr_ok;
  assign MEM_WE = w_wr_ok ? bus.WSTRB_S : 4'b0000;
  assign MEM_A  = w_wr_ok ? r_addr      : r_last_a;
  assign MEM_DI = w_wr_ok ? bus.WDATA_S : r_last_di;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state   <= S_IDLE;
      r_id      <= '0;
      r_last_a  <= '0;
      r_last_di <= '0;
`ifdef AXI_WR_SLV_ERRCHK_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_aw_err  <= 1'b0;
      r_over    <= 1'b0;
`endif
    end else begin
      if (w_wr_ok) begin
        r_last_a  <= r_addr;
        r_last_di <= bus.WDATA_S;
      end
      case (r_state)
        S_IDLE: begin
          if (w_aw_hs) begin
            r_id    <= bus.AWID_S;
            r_state <= S_DATA;
`ifdef AXI_WR_SLV_ERRCHK_EN
            r_cnt    <= '0;
            r_aw_err <= w_aw_bad;
            r_err    <= w_aw_bad;
            r_over   <= 1'b0;
`endif
          end
        end
        S_DATA: begin
          if (w_w_hs) begin
`ifdef AXI_WR_SLV_ERRCHK_EN
            if (r_cnt != 4'hF) r_cnt <= r_cnt + 4'd1;
            if (w_beat_err) r_err <= 1'b1;
            if ((r_cnt == r_len) && !bus.WLAST_S) r_over <= 1'b1;
`endif
            if (bus.WLAST_S) r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.BREADY_S) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Burst address/type carry no reset: they are always reloaded by the AW handshake.
  always_ff @(posedge ACLK) begin
    if (w_aw_hs) begin
      r_addr  <= bus.AWADDR_S[MEM_ADDR_WIDTH+1:2];
      r_burst <= bus.AWBURST_S;
`ifdef AXI_WR_SLV_ERRCHK_EN
      r_len   <= bus.AWLEN_S;
`endif
    end else if (w_w_hs) begin
      r_addr <= w_addr_nxt;
    end
  end

endmodule

// File: tb/tb_axi_sram_write_slave.sv
// Scoreboard bench for axi_sram_write_slave; expectations follow AXI_WR_SLV_ERRCHK_EN.
module tb_axi_sram_write_slave;

  localparam int IDW = 8;
  localparam int MAW = 14;
`ifdef AXI_WR_SLV_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_sram_write_slave_if #(.ID_WIDTH(IDW)) bus();

  logic           mem_cs;
  logic [3:0]     mem_we;
  logic [MAW-1:0] mem_a;
  logic [31:0]    mem_di;

  axi_sram_write_slave #(.ID_WIDTH(IDW), .MEM_ADDR_WIDTH(MAW)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus),
    .MEM_CS (mem_cs),
    .MEM_WE (mem_we),
    .MEM_A  (mem_a),
    .MEM_DI (mem_di)
  );

  typedef struct packed {
    logic [MAW-1:0] a;
    logic [3:0]     we;
    logic [31:0]    di;
  } wr_t;

  wr_t        exp_wr[$];
  logic [9:0] exp_b[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S, bus.BID_S, bus.BRESP_S,
            mem_cs, mem_we, mem_a, mem_di};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT writes SRAM or completes a B handshake.
  initial begin
    wr_t        e;
    logic [9:0] eb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_cs) begin
          if (exp_wr.size() == 0) chk("unexpected_write", {mem_a, mem_we}, 0);
          else begin
            e = exp_wr.pop_front();
            chk("mem_write", {mem_a, mem_we, mem_di}, e);
          end
        end
        if (bus.BVALID_S && bus.BREADY_S) begin
          if (exp_b.size() == 0) chk("unexpected_bresp", {bus.BID_S, bus.BRESP_S}, 0);
          else begin
            eb = exp_b.pop_front();
            chk("b_response", {bus.BID_S, bus.BRESP_S}, eb);
          end
        end
      end
    end
  end

  task automatic aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    bit got = 0;
    int t = 0;
    bus.AWID_S = id; bus.AWADDR_S = addr; bus.AWLEN_S = len;
    bus.AWSIZE_S = size; bus.AWBURST_S = burst; bus.AWVALID_S = 1'b1;
    do begin
      @(negedge clk); got = bus.AWREADY_S;
      @(posedge clk); #1; t++;
    end while (!got && t < 50);
    if (!got) chk("aw_timeout", 64'(got), 1);
    bus.AWVALID_S = 1'b0;
  endtask

  task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic last,
                       input bit wr, input logic [MAW-1:0] a);
    bit got = 0;
    int t = 0;
    if (wr) exp_wr.push_back({a, s, d});
    bus.WDATA_S = d; bus.WSTRB_S = s; bus.WLAST_S = last; bus.WVALID_S = 1'b1;
    do begin
      @(negedge clk); got = bus.WREADY_S;
      @(posedge clk); #1; t++;
    end while (!got && t < 50);
    if (!got) chk("w_timeout", 64'(got), 1);
    bus.WVALID_S = 1'b0; bus.WLAST_S = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end while (!bus.AWREADY_S && t < 50);
    chk("idle_timeout", 64'(bus.AWREADY_S), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.AWID_S = '0; bus.AWADDR_S = '0; bus.AWLEN_S = '0; bus.AWSIZE_S = '0;
    bus.AWBURST_S = '0; bus.AWVALID_S = 1'b1; bus.WDATA_S = '0; bus.WSTRB_S = '0;
    bus.WLAST_S = 1'b0; bus.WVALID_S = 1'b0; bus.BREADY_S = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    bus.AWVALID_S = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    // W beats in IDLE are ignored
    bus.WVALID_S = 1'b1; bus.WSTRB_S = 4'hF; bus.WDATA_S = 32'hDEAD;
    @(negedge clk); chk("wready_in_idle", 64'(bus.WREADY_S), 0);
    @(posedge clk); #1; bus.WVALID_S = 1'b0;

    // INCR burst of 4 from byte 0x10
    exp_b.push_back({8'h5A, 2'b00});
    aw(8'h5A, 32'h10, 4'd3, 3'b010, 2'b01);
    for (int i = 0; i < 4; i++)
      wbeat(32'hA0 + 32'(i), 4'hF, (i == 3), 1, 14'(4 + i));
    wait_idle();

    // Single beat, B held off for 5 cycles
    bus.BREADY_S = 1'b0;
    exp_b.push_back({8'h33, 2'b00});
    aw(8'h33, 32'h100, 4'd0, 3'b010, 2'b01);
    wbeat(32'h1234_5678, 4'b0101, 1, 1, 14'h40);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("b_hold", {bus.BVALID_S, bus.BID_S, bus.BRESP_S}, {1'b1, 8'h33, 2'b00});
    end
    @(posedge clk); #1; bus.BREADY_S = 1'b1;
    @(posedge clk); #1; bus.BREADY_S = 1'b0;
    @(negedge clk);
    chk("awready_after_b", {bus.AWREADY_S, bus.BVALID_S}, {1'b1, 1'b0});
    @(posedge clk); #1; bus.BREADY_S = 1'b1;

    // INCR wraparound at top word
    exp_b.push_back({8'h71, 2'b00});
    aw(8'h71, 32'h0000_FFFC, 4'd1, 3'b010, 2'b01);
    wbeat(32'hB0, 4'hF, 0, 1, 14'h3FFF);
    wbeat(32'hB1, 4'hF, 1, 1, 14'h0000);
    wait_idle();

    // FIXED burst holds the address
    exp_b.push_back({8'h12, 2'b00});
    aw(8'h12, 32'h600, 4'd2, 3'b010, 2'b00);
    for (int i = 0; i < 3; i++)
      wbeat(32'hC0 + 32'(i), 4'h3, (i == 2), 1, 14'h180);
    wait_idle();

    // Illegal AWSIZE
    exp_b.push_back({8'h21, ERRCHK ? 2'b10 : 2'b00});
    aw(8'h21, 32'h200, 4'd1, 3'b001, 2'b01);
    wbeat(32'hD0, 4'hF, 0, !ERRCHK, 14'h80);
    wbeat(32'hD1, 4'hF, 1, !ERRCHK, 14'h81);
    wait_idle();

    // Early WLAST: LEN=3, last on beat 2
    exp_b.push_back({8'h22, ERRCHK ? 2'b10 : 2'b00});
    aw(8'h22, 32'h300, 4'd3, 3'b010, 2'b01);
    wbeat(32'hE0, 4'h8, 0, 1, 14'hC0);
    wbeat(32'hE1, 4'h8, 1, 1, 14'hC1);
    wait_idle();

    // Overrun: LEN=0, last on beat 3
    exp_b.push_back({8'h23, ERRCHK ? 2'b10 : 2'b00});
    aw(8'h23, 32'h500, 4'd0, 3'b010, 2'b01);
    wbeat(32'hF0, 4'hF, 0, 1, 14'h140);
    wbeat(32'hF1, 4'hF, 0, !ERRCHK, 14'h141);
    wbeat(32'hF2, 4'hF, 1, !ERRCHK, 14'h142);
    wait_idle();

    // Reset in the middle of a LEN=3 burst: no B response afterwards
    aw(8'h44, 32'h400, 4'd3, 3'b010, 2'b01);
    wbeat(32'h90, 4'hF, 0, 1, 14'h100);
    wbeat(32'h91, 4'hF, 0, 1, 14'h101);
    rst = 1'b1;
    @(negedge clk); chk("midburst_reset_outputs", all_outs(), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_reset_state", {bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S}, {1'b1, 1'b0, 1'b0});
    repeat (3) @(negedge clk);
    chk("no_b_after_reset", 64'(bus.BVALID_S), 0);

    // Fresh burst after reset still works
    exp_b.push_back({8'h55, 2'b00});
    @(posedge clk); #1;
    aw(8'h55, 32'h20, 4'd0, 3'b010, 2'b01);
    wbeat(32'h7777_0001, 4'hF, 1, 1, 14'h8);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("write_queue_drained", 64'(exp_wr.size()), 0);
    chk("b_queue_drained", 64'(exp_b.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_sram_write_slave.md
# axi_sram_write_slave

Slave-side AXI4 write responder that terminates the interconnect's write address, write data and write response channels for one SRAM-backed slave. It accepts one AW request, absorbs the W beats the interconnect forwards, converts each accepted beat into a byte-strobed SRAM write, and returns a single B response. The block sits between the bus and the SRAM macro wrapper of each writable slave port (S1–S4).

## Interface
Parameters:
- ID_WIDTH, 8, width of AWID_S/BID_S (4-bit master ID plus 4-bit transaction ID)
- MEM_ADDR_WIDTH, 14, SRAM word-address width

Ports (one clock; reset is asynchronous and active-high):
- ACLK  in  1  bus clock, all state on rising edge
- ARESET  in  1  asynchronous, active-high reset
- AWID_S  in  ID_WIDTH  write ID
- AWADDR_S  in  32  byte start address
- AWLEN_S  in  4  beats minus one
- AWSIZE_S  in  3  beat size
- AWBURST_S  in  2  burst type
- AWVALID_S  in  1  address valid
- AWREADY_S  out  1  address ready
- WDATA_S  in  32  write data
- WSTRB_S  in  4  byte strobes
- WLAST_S  in  1  last beat
- WVALID_S  in  1  data valid
- WREADY_S  out  1  data ready
- BID_S  out  ID_WIDTH  response ID
- BRESP_S  out  2  response code
- BVALID_S  out  1  response valid
- BREADY_S  in  1  response ready
- MEM_CS  out  1  SRAM chip select, active-high
- MEM_WE  out  4  SRAM byte write enables, active-high
- MEM_A  out  MEM_ADDR_WIDTH  SRAM word address
- MEM_DI  out  32  SRAM write data

## Operation
- FSM states: IDLE, DATA, RESP. Reset state IDLE.
- IDLE: AWREADY_S=1. On AWVALID_S&AWREADY_S, latch ID, word address AWADDR_S[MEM_ADDR_WIDTH+1:2], AWLEN_S, AWBURST_S, and the error flag. Clear the beat counter. Go to DATA.
- DATA: WREADY_S=1. Each W handshake is one beat:
  - Write-eligible beat: MEM_CS=1, MEM_WE=WSTRB_S, MEM_A=current word address, MEM_DI=WDATA_S, all combinational in the same cycle.
  - Address update: INCR (2'b01) adds 1 modulo 2^MEM_ADDR_WIDTH, so it wraps at the top of the SRAM. FIXED (2'b00) holds the address.
  - Beat counter increments, saturating at 15.
  - A W handshake with WLAST_S=1 goes to RESP.
- Outside write-eligible beats: MEM_CS=0, MEM_WE=0; MEM_A and MEM_DI hold their last values.
- RESP: BVALID_S=1, BID_S=latched ID. BRESP_S=2'b00 OKAY, or 2'b10 SLVERR if the error flag is set. On BREADY_S, go to IDLE.
- Error flag is set by:
  - AWSIZE_S≠3'b010, or AWBURST_S∉{00,01}. Latched at AW. Every beat of that burst is accepted but not written.
  - WLAST_S on beat count≠AWLEN_S (early last).
  - A beat arriving after count already equals AWLEN_S. That beat and all later beats are accepted, not written.
- WVALID_S in IDLE or RESP is ignored (WREADY_S=0). AWVALID_S outside IDLE is not accepted. Only one outstanding transaction.
- Reset mid-burst: FSM returns to IDLE immediately. Partial SRAM writes stay; no B response is issued.

## Timing
- While ARESET=1, all outputs are 0, including AWREADY_S (masked by reset).
- AW handshake in cycle N → WREADY_S=1 in N+1.
- W handshake in cycle M → SRAM write in cycle M (zero latency).
- WLAST handshake in cycle M → BVALID_S=1 in M+1.
- B handshake in cycle K → AWREADY_S=1 in K+1.
- Single-beat write minimum is 3 cycles. Burst throughput is one beat per cycle.
- BVALID_S, BID_S and BRESP_S stay stable until BREADY_S.

## Configuration
- AXI_WR_SLV_ERRCHK_EN defined: all error detection as above; SLVERR reported.
- Undefined:
  - No error flag; BRESP_S is always 2'b00.
  - Every beat up to and including WLAST_S is written, whatever AWSIZE_S or the beat count.
  - Non-FIXED bursts are treated as INCR.

## Structure
- Shared package axi_pkg holds:
  - Burst encodings BURST_FIXED/BURST_INCR.
  - Response codes RESP_OKAY/RESP_SLVERR.
  - SIZE_4B constant.
- FSM state enum is local to the module.
- No sub-module is needed; address/beat generation stays inline.

## Test plan
- AW addr 0x0000_0010, LEN=3, INCR, SIZE=2; 4 beats 0xA0..0xA3 with WSTRB=F, WLAST on beat 4 → MEM_A 4,5,6,7 with MEM_WE=F; BRESP=00, BID equals AWID.
- Single beat, WSTRB=4'b0101, BREADY held low 5 cycles → MEM_WE=0101; BVALID/BID/BRESP stable for 5 cycles; AWREADY_S=1 one cycle after the B handshake.
- INCR LEN=1 at word address 2^14−1 → second beat writes MEM_A=0 (wraparound).
- ERRCHK on, AWSIZE=3'b001 → beats accepted, MEM_CS=0 throughout, BRESP=10. LEN=3 with WLAST on beat 2 → BRESP=10, two beats written.
- ARESET pulsed after beat 2 of a LEN=3 burst → all outputs 0 during reset; IDLE with AWREADY_S=1 after release; no B response issued.
- ERRCHK off, LEN=0 with WLAST on beat 3 → all 3 beats written, BRESP=00.
